// File: rtl/cache_fill_arbiter_pkg.sv
// Shared types, constants and address helper for the cache fill arbiter.
package cache_fill_arbiter_pkg;

    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned BLOCK_WORDS = 8;
    localparam int unsigned WORD_BYTES  = 2;
    localparam int unsigned IDX_W       = $clog2(BLOCK_WORDS);

    localparam logic [ADDR_W-1:0] BLOCK_MASK = 16'hFFF0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    // Byte address of word idx within the block starting at base (16-bit wrap).
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [IDX_W-1:0]  idx);
        return base + (ADDR_W'(idx) * ADDR_W'(WORD_BYTES));
    endfunction

endpackage

// File: rtl/cache_fill_arbiter_fill_counter.sv
// Block word counter: counts enabled cycles, wraps after the last word.
module fill_counter
    import cache_fill_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [IDX_W-1:0] cnt,
    output logic             tc
);

    // Count up on enable; clear is asynchronous.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + IDX_W'(1);
        end
    end

    assign tc = (cnt == IDX_W'(BLOCK_WORDS - 1));

endmodule

// File: rtl/cache_fill_arbiter.sv
// Arbitrates I-cache fills, D-cache fills and D-side write-through stores
// onto a single main memory port.
module cache_fill_arbiter
    import cache_fill_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_miss_addr,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [DATA_W-1:0] d_wr_data,
    input  logic              mem_data_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] fill_data,
    output logic              fill_word_en,
    output logic [IDX_W-1:0]  fill_word_idx,
    output logic              fill_to_dcache,
    output logic              fill_tag_we,
    output logic              i_fill_done,
    output logic              d_fill_done,
    output logic              d_wr_done,
    output logic              busy
);

    arb_state_t        state;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_dside;
    logic              issue_done;

    logic [IDX_W-1:0]  issue_cnt;
    logic              issue_tc;
    logic              issue_en;
    logic [IDX_W-1:0]  recv_cnt;
    logic              recv_tc;

    // Issue stops after the last block word has been put on the bus.
    assign issue_en = (state == ST_FILL) && !issue_done;

    fill_counter u_issue_cnt (
        .clk (clk),
        .clr (rst),
        .en  (issue_en),
        .cnt (issue_cnt),
        .tc  (issue_tc)
    );

    fill_counter u_recv_cnt (
        .clk (clk),
        .clr (rst),
        .en  (fill_word_en),
        .cnt (recv_cnt),
        .tc  (recv_tc)
    );

    // Returned words are forwarded in the cycle they arrive; stray valids are dropped.
    assign fill_word_en   = (state == ST_FILL) && mem_data_valid;
    assign fill_data      = fill_word_en ? mem_rdata : '0;
    assign fill_word_idx  = fill_word_en ? recv_cnt : '0;
    assign fill_tag_we    = fill_word_en && recv_tc;
    assign fill_to_dcache = (state == ST_FILL) && lat_dside;
    assign busy           = (state != ST_IDLE);

    // Arbitration FSM with registered memory-port outputs and done pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            lat_addr    <= '0;
            lat_dside   <= 1'b0;
            issue_done  <= 1'b0;
            mem_enable  <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            i_fill_done <= 1'b0;
            d_fill_done <= 1'b0;
            d_wr_done   <= 1'b0;
        end else begin
            i_fill_done <= 1'b0;
            d_fill_done <= 1'b0;
            d_wr_done   <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (d_miss) begin
                        state      <= ST_FILL;
                        lat_addr   <= d_miss_addr & BLOCK_MASK;
                        lat_dside  <= 1'b1;
                        mem_enable <= 1'b1;
                        mem_addr   <= d_miss_addr & BLOCK_MASK;
                    end else if (d_wr_req) begin
                        state      <= ST_WRITE;
                        lat_addr   <= d_wr_addr;
                        lat_dside  <= 1'b1;
                        mem_enable <= 1'b1;
                        mem_wr     <= 1'b1;
                        mem_addr   <= d_wr_addr;
                        mem_wdata  <= d_wr_data;
                    end else if (i_miss) begin
                        state      <= ST_FILL;
                        lat_addr   <= i_miss_addr & BLOCK_MASK;
                        lat_dside  <= 1'b0;
                        mem_enable <= 1'b1;
                        mem_addr   <= i_miss_addr & BLOCK_MASK;
                    end
                end
                ST_WRITE: begin
                    state      <= ST_DONE;
                    d_wr_done  <= 1'b1;
                    mem_enable <= 1'b0;
                    mem_wr     <= 1'b0;
                    mem_addr   <= '0;
                    mem_wdata  <= '0;
                end
                ST_FILL: begin
                    if (fill_tag_we) begin
                        state       <= ST_DONE;
                        d_fill_done <= lat_dside;
                        i_fill_done <= !lat_dside;
                        issue_done  <= 1'b0;
                        mem_enable  <= 1'b0;
                        mem_addr    <= '0;
                    end else if (!issue_done) begin
                        if (issue_tc) begin
                            issue_done <= 1'b1;
                            mem_enable <= 1'b0;
                            mem_addr   <= '0;
                        end else begin
                            mem_addr <= word_addr(lat_addr, IDX_W'(issue_cnt + IDX_W'(1)));
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cache_fill_arbiter.md
CACHE_FILL_ARBITER -- requirements
Module: cache_fill_arbiter

Interface
REQ-001 SHALL use one clock and one reset, the reset asynchronous and active-high, with ports named clk and rst as elsewhere in the codebase.
REQ-002 SHALL have these ports, clock and reset first:
- clk  in  1  rising-edge clock.
- rst  in  1  async active-high reset.
- i_miss  in  1  I-cache miss request; held until i_fill_done.
- i_miss_addr  in  16  I-side miss byte address.
- d_miss  in  1  D-cache miss request; held until d_fill_done.
- d_miss_addr  in  16  D-side miss byte address.
- d_wr_req  in  1  write-through store request; held until d_wr_done.
- d_wr_addr  in  16  store byte address.
- d_wr_data  in  16  store data.
- mem_data_valid  in  1  main memory read-data valid.
- mem_rdata  in  16  main memory read data.
- mem_addr  out  16  main memory address.
- mem_enable  out  1  main memory access strobe.
- mem_wr  out  1  main memory write.
- mem_wdata  out  16  main memory write data.
- fill_data  out  16  word to cache data array.
- fill_word_en  out  1  fill_data valid this cycle.
- fill_word_idx  out  3  word index within block.
- fill_to_dcache  out  1  1 = D-cache target, 0 = I-cache target.
- fill_tag_we  out  1  write tag and valid bit of target cache.
- i_fill_done  out  1  one-cycle pulse.
- d_fill_done  out  1  one-cycle pulse.
- d_wr_done  out  1  one-cycle pulse.
- busy  out  1  state != IDLE.

Function
REQ-003 SHALL implement the states IDLE, WRITE, FILL and DONE.
REQ-004 In IDLE, the arbiter SHALL use fixed priority d_miss > d_wr_req > i_miss; grant takes effect at the clock edge and latches the address (plus data for a write) and the target.
REQ-005 WRITE SHALL last one cycle:
- Drives mem_enable=1, mem_wr=1, mem_addr=latched d_wr_addr, mem_wdata=latched data.
- Next state is DONE, which pulses d_wr_done.
REQ-006 FILL base address SHALL be latched_addr & 16'hFFF0; the block is 8 words of 2 bytes.
REQ-007 FILL SHALL issue one read per cycle for 8 consecutive cycles:
- mem_enable=1, mem_wr=0, mem_addr = base + 2*issue_cnt.
- issue_cnt is 3 bits and runs 0..7, then stops issuing.
REQ-008 During FILL, each mem_data_valid cycle SHALL be forwarded combinationally:
- fill_word_en=1, fill_data=mem_rdata, fill_word_idx=recv_cnt.
- recv_cnt then increments.
- recv_cnt is independent of issue_cnt, so data may return while issue is still in progress.
REQ-009 On the 8th valid word (recv_cnt==7), fill_tag_we SHALL assert in the same cycle, and the next state is DONE.
REQ-010 DONE SHALL last one cycle:
- Pulses i_fill_done or d_fill_done (fill) or d_wr_done (write).
- Returns to IDLE; re-arbitration happens in IDLE on the following cycle.
REQ-011 mem_data_valid outside FILL, or after 8 words have been received, SHALL be ignored.
REQ-012 If i_miss and d_miss rise in the same cycle, D SHALL be serviced first; I is granted in the IDLE cycle after D's DONE.
REQ-013 Requests deasserting mid-service SHALL NOT abort the service.
REQ-014 fill_to_dcache SHALL reflect the latched target for the whole of FILL.
REQ-015 All outputs except busy SHALL be 0 in IDLE and DONE (apart from the done pulses).
REQ-016 Address arithmetic SHALL be 16-bit wrap-around; the block at 16'hFFF0 issues addresses up to 16'hFFFE with no carry out.

Reset
REQ-017 rst SHALL force, asynchronously, state=IDLE, issue_cnt=0, recv_cnt=0, latched registers=0, and all outputs=0.
REQ-018 rst asserted mid-FILL or mid-WRITE SHALL abandon the access with no done pulse and no fill_tag_we.
REQ-019 Requests still held when rst deasserts SHALL be re-arbitrated from IDLE.

Structure
REQ-020 The shared package SHALL hold:
- The state enumeration.
- BLOCK_WORDS=8.
- WORD_BYTES=2.
- BLOCK_MASK=16'hFFF0.
REQ-021 The design SHALL contain one sub-module, fill_counter: a 3-bit counter with enable, async clear, and a terminal-count output, instanced twice (issue and receive).

Verification
REQ-022 The bench SHALL cover at least these scenarios:
- i_miss, addr 16'h0046, memory latency 4 → mem_addr 16'h0040..16'h004E on 8 cycles; words idx 0..7; fill_tag_we on idx 7; i_fill_done exactly 13 cycles after grant.
- i_miss and d_miss same cycle, addrs 16'h0100/16'h2208 → D fill of 16'h2200 block completes first; I fill of 16'h0100 follows; fill_to_dcache 1 then 0.
- d_wr_req, addr 16'h3000, data 16'hBEEF → one cycle with mem_enable=mem_wr=1, mem_wdata 16'hBEEF; d_wr_done two cycles after grant.
- d_miss at 16'hFFF2 → addresses 16'hFFF0..16'hFFFE with no wrap beyond.
- rst pulse after the 3rd returned word → all outputs 0 immediately; no done or tag write; with d_miss still held, a full refill restarts at idx 0.
- Spurious mem_data_valid in IDLE, plus a 9th valid in FILL → no fill_word_en for either.
